arm_word_packer: RTL and testbench

Upstream feeder for the RSA command wrapper: accepts a 32-bit word stream from the ARM side and assembles it into full `TX_SIZE`-bit operand blocks (ciphertext, p‖dp, R2p‖Rp) presented on a valid/ready port that drives the wrapper's `arm_to_fpga_data` / `arm_to_fpga_data_valid` / `arm_to_fpga_data_ready` inputs. It double-buffers one completed block while the next block streams in, and supports short blocks terminated by `s_last` with zero-fill.

---
 rtl/arm_word_packer.sv | 120 ++++++++++++
 tb/tb_arm_word_packer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/arm_word_packer.sv
// Packs a 32-bit word stream into TX_SIZE-bit blocks with one output slot plus
// one hold slot, so a finished block can wait while the output is still busy.
module arm_word_packer #(
  parameter int TX_SIZE = 1024,
  parameter int WORD_W  = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic [WORD_W-1:0]  s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic [TX_SIZE-1:0] m_data,
  output logic [5:0]         m_len,
  output logic               m_valid,
  input  logic               m_ready
);
  localparam int WORDS = TX_SIZE / WORD_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TX_SIZE-1:0] fill_q, fill_d, blk;
  logic [TX_SIZE-1:0] hold_data_q, hold_data_d;
  logic [5:0]         hold_len_q, hold_len_d;
  logic [TX_SIZE-1:0] m_data_q, m_data_d;
  logic [5:0]         m_len_q, m_len_d;
  logic               m_valid_q, m_valid_d;
  logic               acc, done, drain;
  logic [5:0]         blk_len;

  assign s_ready = (state_q == ST_FILL) && !flush;
  assign acc     = s_valid && s_ready;
  assign done    = acc && (s_last || idx_q == LAST_IDX);
  assign drain   = m_valid_q && m_ready;
  assign blk_len = 6'(idx_q) + 6'd1;

  // The incoming word is merged into the fill image; unwritten slots stay zero.
  always_comb begin
    blk = fill_q;
    for (int k = 0; k < WORDS; k++)
      if (acc && idx_q == IDX_W'(k)) blk[k*WORD_W +: WORD_W] = s_data;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    fill_d      = fill_q;
    hold_data_d = hold_data_q;
    hold_len_d  = hold_len_q;
    m_data_d    = m_data_q;
    m_len_d     = m_len_q;
    m_valid_d   = m_valid_q;

    if (drain) m_valid_d = 1'b0;

    if (flush) begin
      state_d     = ST_FILL;
      idx_d       = '0;
      fill_d      = '0;
      hold_data_d = '0;
      hold_len_d  = '0;
    end else if (state_q == ST_FILL) begin
      if (done) begin
        idx_d  = '0;
        fill_d = '0;
        if (!m_valid_q || m_ready) begin
          m_data_d  = blk;
          m_len_d   = blk_len;
          m_valid_d = 1'b1;
        end else begin
          hold_data_d = blk;
          hold_len_d  = blk_len;
          state_d     = ST_HOLD;
        end
      end else if (acc) begin
        idx_d  = idx_q + IDX_W'(1);
        fill_d = blk;
      end
    end else if (drain) begin
      m_data_d    = hold_data_q;
      m_len_d     = hold_len_q;
      m_valid_d   = 1'b1;
      hold_data_d = '0;
      hold_len_d  = '0;
      state_d     = ST_FILL;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_FILL;
      idx_q       <= '0;
      fill_q      <= '0;
      hold_data_q <= '0;
      hold_len_q  <= '0;
      m_data_q    <= '0;
      m_len_q     <= '0;
      m_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fill_q      <= fill_d;
      hold_data_q <= hold_data_d;
      hold_len_q  <= hold_len_d;
      m_data_q    <= m_data_d;
      m_len_q     <= m_len_d;
      m_valid_q   <= m_valid_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_len   = m_len_q;
  assign m_valid = m_valid_q;
endmodule

// File: tb/tb_arm_word_packer.sv
// Directed bench for arm_word_packer: full/short blocks, backpressure into the
// hold slot, same-edge drain and completion, async reset and flush.
module tb_arm_word_packer;
  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          flush = 1'b0;
  logic [31:0]   s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic [1023:0] m_data;
  logic [5:0]    m_len;
  logic          m_valid;
  logic          m_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [1023:0] exp_blk;

  arm_word_packer #(.TX_SIZE(1024), .WORD_W(32)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_len(m_len), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one word for one cycle; inputs change 1 time unit after the edge.
  task automatic push(input logic [31:0] d, input logic last);
    s_valid = 1'b1; s_data = d; s_last = last;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic pulse_ready();
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_len",   64'(m_len),   64'd0);
    chk("rst_m_data_zero", 64'(m_data == '0), 64'd1);
    @(posedge clk); #1; resetn = 1'b1;
    @(posedge clk); #1;

    // 1: full block, words 1..32
    for (int i = 1; i <= 31; i++) push(32'(i), 1'b0);
    chk("full_pre_valid", 64'(m_valid), 64'd0);
    push(32'd32, 1'b0);
    chk("full_valid", 64'(m_valid), 64'd1);
    chk("full_w0",    64'(m_data[31:0]), 64'd1);
    chk("full_w31",   64'(m_data[1023:992]), 64'd32);
    chk("full_len",   64'(m_len), 64'd32);
    pulse_ready();
    chk("full_drained", 64'(m_valid), 64'd0);

    // 2: short block
    push(32'hA, 1'b0); push(32'hB, 1'b0); push(32'hC, 1'b1);
    exp_blk = '0;
    exp_blk[95:0] = {32'hC, 32'hB, 32'hA};
    chk("short_blk", 64'(m_data == exp_blk), 64'd1);
    chk("short_len", 64'(m_len), 64'd3);
    pulse_ready();

    // 3: backpressure into hold
    for (int i = 0; i < 32; i++) push(32'h200 + 32'(i), 1'b0);
    chk("bp_s_ready_b1", 64'(s_ready), 64'd1);
    for (int i = 0; i < 32; i++) push(32'h300 + 32'(i), 1'b0);
    chk("bp_hold_s_ready", 64'(s_ready), 64'd0);
    chk("bp_out_b1", 64'(m_data[31:0]), 64'h200);
    s_valid = 1'b1; s_data = 32'h400; s_last = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1;
    chk("bp_stall_s_ready", 64'(s_ready), 64'd0);
    pulse_ready();
    s_valid = 1'b0; s_last = 1'b0;
    chk("bp_out_b2",   64'(m_data[31:0]), 64'h300);
    chk("bp_out_b2hi", 64'(m_data[1023:992]), 64'h31F);
    chk("bp_valid_b2", 64'(m_valid), 64'd1);
    chk("bp_s_ready_back", 64'(s_ready), 64'd1);
    pulse_ready();
    chk("bp_drained", 64'(m_valid), 64'd0);
    push(32'h400, 1'b1);
    chk("bp_b3_len", 64'(m_len), 64'd1);
    chk("bp_b3_w0",  64'(m_data[31:0]), 64'h400);

    // 4: drain on the same edge the next block completes
    push(32'h500, 1'b0);
    m_ready = 1'b1;
    push(32'h501, 1'b1);
    m_ready = 1'b0;
    chk("sim_valid", 64'(m_valid), 64'd1);
    chk("sim_data",  m_data[63:0], {32'h501, 32'h500});
    chk("sim_len",   64'(m_len), 64'd2);
    chk("sim_no_hold", 64'(s_ready), 64'd1);

    // 5: async reset mid-block (output slot still full from above)
    for (int i = 0; i < 10; i++) push(32'h600 + 32'(i), 1'b0);
    resetn = 1'b0; #2;
    chk("arst_m_valid", 64'(m_valid), 64'd0);
    chk("arst_s_ready", 64'(s_ready), 64'd1);
    chk("arst_m_len",   64'(m_len), 64'd0);
    @(posedge clk); #1; resetn = 1'b1;
    for (int i = 0; i < 32; i++) push(32'h100 + 32'(i), 1'b0);
    chk("arst_w0",  64'(m_data[31:0]), 64'h100);
    chk("arst_w31", 64'(m_data[1023:992]), 64'h11F);
    chk("arst_len", 64'(m_len), 64'd32);
    pulse_ready();

    // 6: flush mid-block
    for (int i = 0; i < 5; i++) push(32'h700 + 32'(i), 1'b0);
    s_valid = 1'b1; s_data = 32'hDEAD; flush = 1'b1; #1;
    chk("flush_s_ready", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; s_valid = 1'b0;
    chk("flush_no_out", 64'(m_valid), 64'd0);
    push(32'h800, 1'b0); push(32'h801, 1'b1);
    exp_blk = '0;
    exp_blk[63:0] = {32'h801, 32'h800};
    chk("flush_blk", 64'(m_data == exp_blk), 64'd1);
    chk("flush_len", 64'(m_len), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
